spike_io_responder: RTL and testbench

- Far-end partner of the neuron processor core. Answers the core's input-spike memory read port (aAddr/aEna → aData) from an on-chip spike RAM that a host loads beforehand.
- Supplies the spike count the core consumes.
- Captures the core's output-phase spike vectors (n, spikes[7:0]) into a FIFO that the host drains.

---
 rtl/spike_io_pkg.sv | 19 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/spike_io_responder.sv | 125 ++++++++++++
 tb/tb_spike_io_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_io_pkg.sv
// Shared definitions for the spike I/O responder.
// Provides default widths, the capture record width and the packed
// capture record type {n, spikes} pushed into the output FIFO.
package spike_io_pkg;

   localparam int ADDR_W_DEF     = 10;
   localparam int DATA_W_DEF     = 10;
   localparam int N_W_DEF        = 5;
   localparam int SPK_W_DEF      = 8;
   localparam int FIFO_DEPTH_DEF = 16;

   localparam int REC_W = N_W_DEF + SPK_W_DEF;

   typedef struct packed {
      logic [N_W_DEF-1:0]   n;
      logic [SPK_W_DEF-1:0] spikes;
   } spike_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with an occupancy counter deciding full/empty.
// Ports:
//   clock, reset  - system clock, async active-low reset
//   push, din     - write request and data (accepted if not full, or full with a pop)
//   pop           - read request (ignored while empty)
//   dout          - head entry, combinational from storage; 0 while empty
//   empty, full   - occupancy flags
module sync_fifo
   import spike_io_pkg::*;
#(
   parameter int WIDTH = REC_W,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   // Gate the head so stale storage never shows while empty.
   assign dout = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spike_io_responder.sv
// Far-end partner of the neuron processor core.
// Serves the core's spike memory reads from a host-loaded RAM, holds the
// spike count, and captures output-phase spike vectors into a FIFO.
// Ports:
//   clock, reset            - system clock, async active-low reset
//   io_aAddr/io_aEna/io_aData - core read port, 1-cycle latency, data held when idle
//   io_spikeCnt             - spike word count for the core (host loaded)
//   io_inOut/io_n/io_spikes - core phase, group index and spike vector
//   ld_valid/ld_ready/ld_addr/ld_data - host RAM write port
//   cnt_we/cnt_data         - host load of io_spikeCnt
//   out_valid/out_ready/out_data - capture FIFO head {n, spikes}
//   ovf, drop_cnt           - sticky overflow flag and saturating drop count
module spike_io_responder
   import spike_io_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int N_W        = N_W_DEF,
   parameter int SPK_W      = SPK_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [ADDR_W-1:0]    io_aAddr,
   input  logic                 io_aEna,
   output logic [DATA_W-1:0]    io_aData,
   output logic [ADDR_W-1:0]    io_spikeCnt,
   input  logic                 io_inOut,
   input  logic [N_W-1:0]       io_n,
   input  logic [SPK_W-1:0]     io_spikes,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   input  logic [ADDR_W-1:0]    ld_addr,
   input  logic [DATA_W-1:0]    ld_data,
   input  logic                 cnt_we,
   input  logic [ADDR_W-1:0]    cnt_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N_W+SPK_W-1:0] out_data,
   output logic                 ovf,
   output logic [7:0]           drop_cnt
);

   logic [DATA_W-1:0] ram [2**ADDR_W];
   logic              prev_in_out;
   logic [N_W-1:0]    prev_n;
   logic              capture;
   logic              fifo_empty;
   logic              fifo_full;
   logic              drop;

   // RAM contents survive reset; only the host write port updates them.
   always_ff @(posedge clock) begin
      if (ld_valid && ld_ready) begin
         ram[ld_addr] <= ld_data;
      end
   end

   // Same-address read/write returns the pre-write word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         io_aData <= '0;
      end else if (io_aEna) begin
         io_aData <= ram[io_aAddr];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ld_ready    <= 1'b0;
         io_spikeCnt <= '0;
      end else begin
         ld_ready <= 1'b1;
         if (cnt_we) begin
            io_spikeCnt <= cnt_data;
         end
      end
   end

   // Capture edge detector: first cycle of an output phase, or a new group
   // index within it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_in_out <= 1'b0;
         prev_n      <= '0;
      end else begin
         prev_in_out <= io_inOut;
         prev_n      <= io_n;
      end
   end

   assign capture = io_inOut && (!prev_in_out || (io_n != prev_n));

   // Full implies non-empty, so out_ready alone tells whether the head leaves.
   assign drop = capture && fifo_full && !out_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         ovf <= 1'b1;
         if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (N_W + SPK_W),
      .DEPTH (FIFO_DEPTH)
   ) u_capture_fifo (
      .clock (clock),
      .reset (reset),
      .push  (capture),
      .din   ({io_n, io_spikes}),
      .pop   (out_ready),
      .dout  (out_data),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_spike_io_responder.sv
module tb_spike_io_responder;
   import spike_io_pkg::*;

   localparam int AW    = 10;
   localparam int DW    = 10;
   localparam int NW    = 5;
   localparam int SW    = 8;
   localparam int DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] io_aAddr = '0;
   logic          io_aEna = 1'b0;
   logic [DW-1:0] io_aData;
   logic [AW-1:0] io_spikeCnt;
   logic          io_inOut = 1'b0;
   logic [NW-1:0] io_n = '0;
   logic [SW-1:0] io_spikes = '0;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic          cnt_we = 1'b0;
   logic [AW-1:0] cnt_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [NW+SW-1:0] out_data;
   logic          ovf;
   logic [7:0]    drop_cnt;

   spike_io_responder dut (
      .clock       (clock),
      .reset       (reset),
      .io_aAddr    (io_aAddr),
      .io_aEna     (io_aEna),
      .io_aData    (io_aData),
      .io_spikeCnt (io_spikeCnt),
      .io_inOut    (io_inOut),
      .io_n        (io_n),
      .io_spikes   (io_spikes),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .cnt_we      (cnt_we),
      .cnt_data    (cnt_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .ovf         (ovf),
      .drop_cnt    (drop_cnt)
   );

   always #5 clock = ~clock;

   // Behavioural model
   logic [DW-1:0] m_ram [1024];
   logic [DW-1:0] m_adata = '0;
   logic [AW-1:0] m_cnt = '0;
   bit            m_ldr = 1'b0;
   bit            m_pio = 1'b0;
   logic [NW-1:0] m_pn = '0;
   spike_rec_t    m_q[$];
   bit            m_ovf = 1'b0;
   int            m_drop = 0;

   always @(posedge clock or negedge reset) begin
      bit cap;
      bit pop;
      if (!reset) begin
         m_adata = '0;
         m_cnt   = '0;
         m_ldr   = 1'b0;
         m_pio   = 1'b0;
         m_pn    = '0;
         m_q.delete();
         m_ovf   = 1'b0;
         m_drop  = 0;
      end else begin
         if (io_aEna) m_adata = m_ram[io_aAddr];
         if (ld_valid && m_ldr) m_ram[ld_addr] = ld_data;
         m_ldr = 1'b1;
         if (cnt_we) m_cnt = cnt_data;
         cap = io_inOut && (!m_pio || (io_n != m_pn));
         pop = out_ready && (m_q.size() > 0);
         if (cap) begin
            if (m_q.size() < DEPTH || pop) begin
               m_q.push_back({io_n, io_spikes});
            end else begin
               m_ovf = 1'b1;
               if (m_drop < 255) m_drop++;
            end
         end
         if (pop) void'(m_q.pop_front());
         m_pio = io_inOut;
         m_pn  = io_n;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, wanted %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clock) begin
      chk("aData",     32'(io_aData), 32'(m_adata));
      chk("spikeCnt",  32'(io_spikeCnt), 32'(m_cnt));
      chk("ld_ready",  32'(ld_ready), 32'(m_ldr));
      chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      chk("out_data",  32'(out_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
      chk("ovf",       32'(ovf), 32'(m_ovf));
      chk("drop_cnt",  32'(drop_cnt), 32'(m_drop));
   end

   initial begin
      logic [NW+SW-1:0] exp4 [4];
      logic [NW-1:0]    nseq [6];
      logic [SW-1:0]    sseq [6];
      int               popped;
      int               rdy_pct;

      exp4[0] = {5'd0, 8'h81};
      exp4[1] = {5'd1, 8'h42};
      exp4[2] = {5'd2, 8'h00};
      exp4[3] = {5'd3, 8'hFF};
      nseq[0] = 5'd0; nseq[1] = 5'd0; nseq[2] = 5'd1;
      nseq[3] = 5'd2; nseq[4] = 5'd2; nseq[5] = 5'd3;
      sseq[0] = 8'h81; sseq[1] = 8'h5A; sseq[2] = 8'h42;
      sseq[3] = 8'h00; sseq[4] = 8'hC3; sseq[5] = 8'hFF;

      repeat (3) @(negedge clock);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("ld_ready_up", 32'(ld_ready), 32'd1);

      // Preload whole RAM so every later read has a known value
      for (int a = 0; a < 1024; a++) begin
         ld_valid = 1'b1;
         ld_addr  = 10'(a);
         ld_data  = 10'($urandom);
         @(negedge clock);
      end
      ld_addr = 10'd5; ld_data = 10'h2A3; @(negedge clock);
      ld_addr = 10'd6; ld_data = 10'h011; @(negedge clock);
      ld_addr = 10'd9; ld_data = 10'h100; @(negedge clock);
      ld_valid = 1'b0;

      // Back-to-back reads
      io_aEna = 1'b1; io_aAddr = 10'd5; @(negedge clock);
      chk("read5", 32'(io_aData), 32'h2A3);
      io_aAddr = 10'd6; @(negedge clock);
      chk("read6", 32'(io_aData), 32'h011);
      io_aEna = 1'b0; io_aAddr = 10'd5; @(negedge clock);
      chk("read_hold", 32'(io_aData), 32'h011);

      // Read during write to the same address
      ld_valid = 1'b1; ld_addr = 10'd9; ld_data = 10'h3FF;
      io_aEna = 1'b1; io_aAddr = 10'd9; @(negedge clock);
      chk("rw_old", 32'(io_aData), 32'h100);
      ld_valid = 1'b0; @(negedge clock);
      chk("rw_new", 32'(io_aData), 32'h3FF);
      io_aEna = 1'b0;

      // Spike count load and hold
      cnt_we = 1'b1; cnt_data = 10'd37; @(negedge clock);
      chk("cnt_load", 32'(io_spikeCnt), 32'd37);
      cnt_we = 1'b0; cnt_data = 10'd5;
      repeat (3) @(negedge clock);
      chk("cnt_hold", 32'(io_spikeCnt), 32'd37);

      // Capture sequence: four records expected
      for (int i = 0; i < 6; i++) begin
         io_inOut = 1'b1; io_n = nseq[i]; io_spikes = sseq[i];
         @(negedge clock);
      end
      io_inOut = 1'b0; @(negedge clock);
      @(negedge clock);
      chk("cap_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("cap_rec", 32'(out_data), 32'(exp4[k]));
         @(negedge clock);
      end
      chk("cap_empty", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Overflow: 16 fill, 3 drops, then a capture alongside a pop
      for (int i = 0; i < 19; i++) begin
         io_inOut = 1'b1; io_n = 5'(i); io_spikes = 8'($urandom);
         @(negedge clock);
      end
      chk("ovf_set", 32'(ovf), 32'd1);
      chk("drop3", 32'(drop_cnt), 32'd3);
      io_n = 5'd19; out_ready = 1'b1; @(negedge clock);
      chk("drop_still3", 32'(drop_cnt), 32'd3);
      io_inOut = 1'b0; out_ready = 1'b0; @(negedge clock);
      out_ready = 1'b1;
      popped = 0;
      for (int k = 0; k < 40 && out_valid; k++) begin
         @(negedge clock);
         popped++;
      end
      chk("occupancy16", 32'(popped), 32'd16);
      out_ready = 1'b0;

      // Async reset mid-capture with 5 entries queued
      for (int i = 0; i < 5; i++) begin
         io_inOut = 1'b1; io_n = 5'(i + 8); io_spikes = 8'($urandom);
         @(negedge clock);
      end
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      io_n = 5'd20;
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_ovf", 32'(ovf), 32'd0);
      chk("arst_adata", 32'(io_aData), 32'd0);
      chk("arst_drop", 32'(drop_cnt), 32'd0);
      @(negedge clock);
      reset = 1'b1; io_inOut = 1'b0;
      @(negedge clock);
      io_aEna = 1'b1; io_aAddr = 10'd5; @(negedge clock);
      chk("ram_kept", 32'(io_aData), 32'h2A3);
      io_aEna = 1'b0;

      // Randomized traffic
      rdy_pct = 50;
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) rdy_pct = int'($urandom_range(5, 95));
         if ($urandom_range(0, 99) < 12) io_inOut = ~io_inOut;
         if ($urandom_range(0, 99) < 40) io_n = 5'($urandom_range(0, 3));
         io_spikes = 8'($urandom);
         io_aEna   = 1'($urandom);
         io_aAddr  = 10'($urandom);
         ld_valid  = ($urandom_range(0, 99) < 20);
         ld_addr   = 10'($urandom);
         ld_data   = 10'($urandom);
         cnt_we    = ($urandom_range(0, 99) < 5);
         cnt_data  = 10'($urandom);
         out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
         if (i == 2000) begin
            #2 reset = 1'b0;
            @(negedge clock);
            reset = 1'b1;
         end
         @(negedge clock);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
